// File: rtl/sincos_dispatch.sv
// sincos_dispatch: request front-end for the single-issue sin/cos core.
// Host operations are queued in a small register FIFO and issued one at a
// time when the core reports idle. The core's one-cycle result pulse is
// caught in a holding register and returned with the host tag. A watchdog
// turns a missing result into an error response so the queue never stalls.
module sincos_dispatch #(
    parameter int EXP_WIDTH  = 8,
    parameter int FRAC_WIDTH = 32,
    parameter int TAG_WIDTH  = 4,
    parameter int DEPTH      = 4,
    parameter int TIMEOUT    = 255
) (
    input  logic                       i_clk,
    input  logic                       i_rstn,
    input  logic                       i_req_valid,
    output logic                       o_req_ready,
    input  logic                       i_req_sign,
    input  logic [EXP_WIDTH-1:0]       i_req_exp,
    input  logic [FRAC_WIDTH-1:0]      i_req_frac,
    input  logic                       i_req_sincos,
    input  logic [TAG_WIDTH-1:0]       i_req_tag,
    output logic                       o_core_valid,
    output logic                       o_core_sign,
    output logic [EXP_WIDTH-1:0]       o_core_exp,
    output logic [FRAC_WIDTH-1:0]      o_core_frac,
    output logic                       o_core_sincos,
    input  logic                       i_core_allow,
    input  logic                       i_core_valid,
    input  logic                       i_core_sign,
    input  logic [EXP_WIDTH-1:0]       i_core_exp,
    input  logic [FRAC_WIDTH-1:0]      i_core_frac,
    input  logic                       i_core_sincos,
    output logic                       o_rsp_valid,
    input  logic                       i_rsp_ready,
    output logic                       o_rsp_sign,
    output logic [EXP_WIDTH-1:0]       o_rsp_exp,
    output logic [FRAC_WIDTH-1:0]      o_rsp_frac,
    output logic                       o_rsp_sincos,
    output logic [TAG_WIDTH-1:0]       o_rsp_tag,
    output logic                       o_rsp_err,
    output logic [$clog2(DEPTH):0]     o_count,
    output logic                       o_err
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int WD_W  = 16;

    typedef struct packed {
        logic                  sign;
        logic [EXP_WIDTH-1:0]  exp;
        logic [FRAC_WIDTH-1:0] frac;
        logic                  sincos;
        logic [TAG_WIDTH-1:0]  tag;
    } req_t;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_HOLD  = 2'd3
    } state_t;

    state_t               state, state_nxt;

    req_t                 fifo_mem [DEPTH];
    req_t                 push_entry;
    req_t                 head_entry;
    logic [PTR_W-1:0]     wr_ptr;
    logic [PTR_W-1:0]     rd_ptr;
    logic [CNT_W-1:0]     count;
    logic                 fifo_empty;
    logic                 push;

    logic [TAG_WIDTH-1:0] tag_q;
    logic [WD_W-1:0]      wdog;
    logic [WD_W-1:0]      wdog_nxt;
    logic                 wdog_hit;

    logic                 can_issue;
    logic                 do_issue;
    logic                 do_accept;
    logic                 do_capture;
    logic                 do_timeout;
    logic                 do_release;

    assign push_entry = '{sign:   i_req_sign,
                          exp:    i_req_exp,
                          frac:   i_req_frac,
                          sincos: i_req_sincos,
                          tag:    i_req_tag};
    assign head_entry = fifo_mem[rd_ptr];

    assign fifo_empty  = (count == '0);
    assign o_req_ready = (count < CNT_W'(DEPTH));
    assign o_count     = count;
    assign push        = i_req_valid & o_req_ready;

    // An issue needs a queued op, an idle core, and no response still owed
    // to the host (or the owed one being consumed this very cycle).
    assign can_issue = !fifo_empty & i_core_allow &
                       ((state == S_IDLE) | ((state == S_HOLD) & i_rsp_ready));

    // The watchdog fires on the cycle whose increment would reach TIMEOUT,
    // so the error response appears TIMEOUT edges after entering WAIT.
    assign wdog_nxt = wdog + WD_W'(1);
    assign wdog_hit = (wdog_nxt == WD_W'(TIMEOUT));

    // FSM state register
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next-state decode
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (can_issue) state_nxt = S_ISSUE;
            end
            S_ISSUE: begin
                if (o_core_valid & i_core_allow) state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (i_core_valid | wdog_hit) state_nxt = S_HOLD;
            end
            S_HOLD: begin
                if (i_rsp_ready) state_nxt = can_issue ? S_ISSUE : S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // FSM action strobes; a result arriving on the timeout cycle wins
    always_comb begin
        do_issue   = can_issue;
        do_accept  = (state == S_ISSUE) & o_core_valid & i_core_allow;
        do_capture = (state == S_WAIT) & i_core_valid;
        do_timeout = (state == S_WAIT) & !i_core_valid & wdog_hit;
        do_release = (state == S_HOLD) & i_rsp_ready;
    end

    // FIFO pointers and occupancy; an issue is the only pop
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)     wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_issue) rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, do_issue})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // FIFO storage; contents are invalidated by the pointers, not cleared
    always_ff @(posedge i_clk) begin
        if (push) fifo_mem[wr_ptr] <= push_entry;
    end

    // Issue register towards the core, held stable until accepted
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            o_core_valid  <= 1'b0;
            o_core_sign   <= 1'b0;
            o_core_exp    <= '0;
            o_core_frac   <= '0;
            o_core_sincos <= 1'b0;
            tag_q         <= '0;
        end else if (do_issue) begin
            o_core_valid  <= 1'b1;
            o_core_sign   <= head_entry.sign;
            o_core_exp    <= head_entry.exp;
            o_core_frac   <= head_entry.frac;
            o_core_sincos <= head_entry.sincos;
            tag_q         <= head_entry.tag;
        end else if (do_accept) begin
            o_core_valid  <= 1'b0;
        end
    end

    // Watchdog: restarts when the core accepts, counts only while waiting
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            wdog <= '0;
        end else if (do_accept) begin
            wdog <= '0;
        end else if (state == S_WAIT) begin
            wdog <= wdog_nxt;
        end
    end

    // Response holding register; only written from WAIT so stray core
    // pulses elsewhere cannot disturb a pending or returned response
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            o_rsp_valid  <= 1'b0;
            o_rsp_sign   <= 1'b0;
            o_rsp_exp    <= '0;
            o_rsp_frac   <= '0;
            o_rsp_sincos <= 1'b0;
            o_rsp_tag    <= '0;
            o_rsp_err    <= 1'b0;
        end else if (do_capture) begin
            o_rsp_valid  <= 1'b1;
            o_rsp_sign   <= i_core_sign;
            o_rsp_exp    <= i_core_exp;
            o_rsp_frac   <= i_core_frac;
            o_rsp_sincos <= i_core_sincos;
            o_rsp_tag    <= tag_q;
            o_rsp_err    <= 1'b0;
        end else if (do_timeout) begin
            o_rsp_valid  <= 1'b1;
            o_rsp_sign   <= 1'b0;
            o_rsp_exp    <= '0;
            o_rsp_frac   <= '0;
            o_rsp_sincos <= o_core_sincos;
            o_rsp_tag    <= tag_q;
            o_rsp_err    <= 1'b1;
        end else if (do_release) begin
            o_rsp_valid  <= 1'b0;
        end
    end

    // Sticky timeout flag, cleared only by reset
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            o_err <= 1'b0;
        end else if (do_timeout) begin
            o_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_sincos_dispatch.sv
// Directed bench for sincos_dispatch: a table of single operations plus
// hand-written sequences for backpressure, stalls, timeout and reset.
module tb_sincos_dispatch;

    logic        clk = 1'b0;
    logic        rstn;
    always #5 clk = ~clk;

    // shared request / core payload and handshake inputs
    logic        req_valid, t_req_valid;
    logic        req_sign, req_sincos;
    logic [7:0]  req_exp;
    logic [31:0] req_frac;
    logic [3:0]  req_tag;
    logic        core_allow, core_valid, t_core_valid;
    logic        core_sign, core_sincos;
    logic [7:0]  core_exp;
    logic [31:0] core_frac;
    logic        rsp_ready;

    // main DUT outputs (TIMEOUT = 255)
    logic        req_ready, oc_valid, oc_sign, oc_sincos;
    logic [7:0]  oc_exp;
    logic [31:0] oc_frac;
    logic        rsp_valid, rsp_sign, rsp_sincos, rsp_err, err;
    logic [7:0]  rsp_exp;
    logic [31:0] rsp_frac;
    logic [3:0]  rsp_tag;
    logic [2:0]  count;

    // short-timeout DUT outputs (TIMEOUT = 8)
    logic        t_req_ready, t_oc_valid, t_oc_sign, t_oc_sincos;
    logic [7:0]  t_oc_exp;
    logic [31:0] t_oc_frac;
    logic        t_rsp_valid, t_rsp_sign, t_rsp_sincos, t_rsp_err, t_err;
    logic [7:0]  t_rsp_exp;
    logic [31:0] t_rsp_frac;
    logic [3:0]  t_rsp_tag;
    logic [2:0]  t_count;

    sincos_dispatch #(.EXP_WIDTH(8), .FRAC_WIDTH(32), .TAG_WIDTH(4), .DEPTH(4), .TIMEOUT(255)) u_dut (
        .i_clk(clk), .i_rstn(rstn),
        .i_req_valid(req_valid), .o_req_ready(req_ready),
        .i_req_sign(req_sign), .i_req_exp(req_exp), .i_req_frac(req_frac),
        .i_req_sincos(req_sincos), .i_req_tag(req_tag),
        .o_core_valid(oc_valid), .o_core_sign(oc_sign), .o_core_exp(oc_exp),
        .o_core_frac(oc_frac), .o_core_sincos(oc_sincos),
        .i_core_allow(core_allow), .i_core_valid(core_valid),
        .i_core_sign(core_sign), .i_core_exp(core_exp), .i_core_frac(core_frac),
        .i_core_sincos(core_sincos),
        .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready),
        .o_rsp_sign(rsp_sign), .o_rsp_exp(rsp_exp), .o_rsp_frac(rsp_frac),
        .o_rsp_sincos(rsp_sincos), .o_rsp_tag(rsp_tag), .o_rsp_err(rsp_err),
        .o_count(count), .o_err(err)
    );

    sincos_dispatch #(.EXP_WIDTH(8), .FRAC_WIDTH(32), .TAG_WIDTH(4), .DEPTH(4), .TIMEOUT(8)) u_dt (
        .i_clk(clk), .i_rstn(rstn),
        .i_req_valid(t_req_valid), .o_req_ready(t_req_ready),
        .i_req_sign(req_sign), .i_req_exp(req_exp), .i_req_frac(req_frac),
        .i_req_sincos(req_sincos), .i_req_tag(req_tag),
        .o_core_valid(t_oc_valid), .o_core_sign(t_oc_sign), .o_core_exp(t_oc_exp),
        .o_core_frac(t_oc_frac), .o_core_sincos(t_oc_sincos),
        .i_core_allow(core_allow), .i_core_valid(t_core_valid),
        .i_core_sign(core_sign), .i_core_exp(core_exp), .i_core_frac(core_frac),
        .i_core_sincos(core_sincos),
        .o_rsp_valid(t_rsp_valid), .i_rsp_ready(rsp_ready),
        .o_rsp_sign(t_rsp_sign), .o_rsp_exp(t_rsp_exp), .o_rsp_frac(t_rsp_frac),
        .o_rsp_sincos(t_rsp_sincos), .o_rsp_tag(t_rsp_tag), .o_rsp_err(t_rsp_err),
        .o_count(t_count), .o_err(t_err)
    );

    typedef struct {
        logic        sign;
        logic [7:0]  exp;
        logic [31:0] frac;
        logic        sincos;
        logic [3:0]  tag;
        int          delay;
        logic        r_sign;
        logic [7:0]  r_exp;
        logic [31:0] r_frac;
        logic        r_sincos;
        logic        e_sign;
        logic [7:0]  e_exp;
        logic [31:0] e_frac;
        logic        e_sincos;
        logic [3:0]  e_tag;
    } vec_t;

    vec_t vecs [3];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
        n_tests++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h, want %0h", name, act, want);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push_req(input bit use_t, input logic s, input logic [7:0] e,
                            input logic [31:0] f, input logic sc, input logic [3:0] t);
        req_sign = s; req_exp = e; req_frac = f; req_sincos = sc; req_tag = t;
        if (use_t) t_req_valid = 1'b1; else req_valid = 1'b1;
        step(1);
        t_req_valid = 1'b0;
        req_valid   = 1'b0;
    endtask

    task automatic wait_core(input int max_cyc);
        bit ok = 1'b0;
        for (int i = 0; i < max_cyc; i++) begin
            step(1);
            if (oc_valid) begin
                ok = 1'b1;
                break;
            end
        end
        chk("wait_core_valid", ok, 1'b1);
    endtask

    task automatic core_pulse(input bit use_t, input logic s, input logic [7:0] e,
                              input logic [31:0] f, input logic sc);
        core_sign = s; core_exp = e; core_frac = f; core_sincos = sc;
        if (use_t) t_core_valid = 1'b1; else core_valid = 1'b1;
        step(1);
        core_valid   = 1'b0;
        t_core_valid = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_time_limit: got expired, want finish");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{sign:1'b0, exp:8'h7E, frac:32'h8000_0000, sincos:1'b1, tag:4'h5, delay:10,
                    r_sign:1'b0, r_exp:8'h7E, r_frac:32'h7A5F_3C01, r_sincos:1'b1,
                    e_sign:1'b0, e_exp:8'h7E, e_frac:32'h7A5F_3C01, e_sincos:1'b1, e_tag:4'h5};
        vecs[1] = '{sign:1'b1, exp:8'h81, frac:32'h0000_0001, sincos:1'b0, tag:4'hA, delay:1,
                    r_sign:1'b1, r_exp:8'h80, r_frac:32'hDEAD_BEEF, r_sincos:1'b0,
                    e_sign:1'b1, e_exp:8'h80, e_frac:32'hDEAD_BEEF, e_sincos:1'b0, e_tag:4'hA};
        vecs[2] = '{sign:1'b0, exp:8'hFF, frac:32'hFFFF_FFFF, sincos:1'b1, tag:4'hF, delay:3,
                    r_sign:1'b1, r_exp:8'h00, r_frac:32'h0000_0000, r_sincos:1'b1,
                    e_sign:1'b1, e_exp:8'h00, e_frac:32'h0000_0000, e_sincos:1'b1, e_tag:4'hF};

        rstn = 1'b0;
        req_valid = 1'b0; t_req_valid = 1'b0;
        req_sign = 1'b0; req_exp = '0; req_frac = '0; req_sincos = 1'b0; req_tag = '0;
        core_allow = 1'b1; core_valid = 1'b0; t_core_valid = 1'b0;
        core_sign = 1'b0; core_exp = '0; core_frac = '0; core_sincos = 1'b0;
        rsp_ready = 1'b1;
        step(2);

        // reset state
        chk("rst_core_valid", oc_valid, 1'b0);
        chk("rst_rsp_valid", rsp_valid, 1'b0);
        chk("rst_count", count, 3'd0);
        chk("rst_err", err, 1'b0);
        chk("rst_req_ready", req_ready, 1'b1);
        rstn = 1'b1;
        step(1);

        // table of single operations, minimum issue latency
        for (int v = 0; v < 3; v++) begin
            chk("vec_req_ready", req_ready, 1'b1);
            push_req(1'b0, vecs[v].sign, vecs[v].exp, vecs[v].frac, vecs[v].sincos, vecs[v].tag);
            chk("vec_count_after_push", count, 3'd1);
            chk("vec_core_valid_e0", oc_valid, 1'b0);
            step(1);
            chk("vec_core_valid_e1", oc_valid, 1'b1);
            chk("vec_core_payload", {oc_sign, oc_exp, oc_frac, oc_sincos},
                {vecs[v].sign, vecs[v].exp, vecs[v].frac, vecs[v].sincos});
            chk("vec_count_after_pop", count, 3'd0);
            step(1);
            chk("vec_core_valid_e2", oc_valid, 1'b0);
            if (vecs[v].delay > 1) step(vecs[v].delay - 1);
            chk("vec_rsp_idle", rsp_valid, 1'b0);
            core_pulse(1'b0, vecs[v].r_sign, vecs[v].r_exp, vecs[v].r_frac, vecs[v].r_sincos);
            chk("vec_rsp_valid", rsp_valid, 1'b1);
            chk("vec_rsp_payload", {rsp_sign, rsp_exp, rsp_frac, rsp_sincos},
                {vecs[v].e_sign, vecs[v].e_exp, vecs[v].e_frac, vecs[v].e_sincos});
            chk("vec_rsp_tag", rsp_tag, vecs[v].e_tag);
            chk("vec_rsp_err", rsp_err, 1'b0);
            step(1);
            chk("vec_rsp_drop", rsp_valid, 1'b0);
        end

        // backpressure fill: core busy, five requests into a depth-4 FIFO
        core_allow = 1'b0;
        for (int k = 0; k < 4; k++)
            push_req(1'b0, 1'b0, 8'h40, 32'h1000_0000 + k, 1'b0, 4'(k));
        chk("fill_count4", count, 3'd4);
        chk("fill_ready0", req_ready, 1'b0);
        req_frac = 32'h1000_0004; req_tag = 4'd4; req_valid = 1'b1;
        step(2);
        chk("fill_no_push_when_full", count, 3'd4);
        core_allow = 1'b1;
        step(1);
        chk("fill_first_pop_count", count, 3'd3);
        chk("fill_first_issue_frac", oc_frac, 32'h1000_0000);
        step(1);
        req_valid = 1'b0;
        chk("fill_fifth_accepted", count, 3'd4);
        for (int k = 0; k < 5; k++) begin
            if (k > 0) begin
                wait_core(20);
                chk("fill_issue_frac", oc_frac, 32'h1000_0000 + k);
                step(1);
            end
            step(2);
            core_pulse(1'b0, 1'b0, 8'h3F, 32'h2000_0000 + k, 1'b0);
            chk("fill_rsp_valid", rsp_valid, 1'b1);
            chk("fill_rsp_tag", rsp_tag, 4'(k));
            chk("fill_rsp_frac", rsp_frac, 32'h2000_0000 + k);
        end
        step(1);
        chk("fill_drained", count, 3'd0);

        // allow stall: payload held while the core is busy, single acceptance
        push_req(1'b0, 1'b1, 8'h33, 32'hCAFE_0006, 1'b1, 4'd6);
        step(1);
        chk("stall_issued", oc_valid, 1'b1);
        core_allow = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step(1);
            chk("stall_valid_held", oc_valid, 1'b1);
            chk("stall_payload_held", {oc_sign, oc_exp, oc_frac}, {1'b1, 8'h33, 32'hCAFE_0006});
        end
        core_allow = 1'b1;
        step(1);
        chk("stall_accepted", oc_valid, 1'b0);
        step(3);
        chk("stall_no_duplicate", oc_valid, 1'b0);
        core_pulse(1'b0, 1'b0, 8'h11, 32'h0000_0066, 1'b1);
        chk("stall_rsp_tag", rsp_tag, 4'd6);
        step(1);

        // response stall: HOLD keeps the response and blocks the next issue
        rsp_ready = 1'b0;
        push_req(1'b0, 1'b0, 8'h10, 32'hAAAA_0007, 1'b0, 4'd7);
        step(2);
        push_req(1'b0, 1'b0, 8'h20, 32'hBBBB_0008, 1'b1, 4'd8);
        core_pulse(1'b0, 1'b1, 8'h44, 32'h1234_5678, 1'b0);
        chk("hold_rsp_valid", rsp_valid, 1'b1);
        for (int i = 0; i < 6; i++) begin
            step(1);
            chk("hold_rsp_stable", {rsp_valid, rsp_sign, rsp_exp, rsp_frac, rsp_tag},
                {1'b1, 1'b1, 8'h44, 32'h1234_5678, 4'd7});
            chk("hold_no_issue", oc_valid, 1'b0);
        end
        chk("hold_count", count, 3'd1);
        rsp_ready = 1'b1;
        step(1);
        chk("hold_rsp_drop", rsp_valid, 1'b0);
        chk("hold_issue_same_cycle", oc_valid, 1'b1);
        chk("hold_issue_frac", oc_frac, 32'hBBBB_0008);
        step(1);
        core_pulse(1'b0, 1'b0, 8'h55, 32'h0000_0088, 1'b1);
        chk("hold_second_tag", rsp_tag, 4'd8);
        step(1);

        // timeout on the TIMEOUT=8 instance: core never answers
        push_req(1'b1, 1'b1, 8'h55, 32'h0000_1234, 1'b1, 4'd9);
        step(1);
        chk("to_issued", t_oc_valid, 1'b1);
        step(1);
        step(7);
        chk("to_not_yet", t_rsp_valid, 1'b0);
        step(1);
        chk("to_rsp_valid", t_rsp_valid, 1'b1);
        chk("to_rsp_err", t_rsp_err, 1'b1);
        chk("to_zero_payload", {t_rsp_sign, t_rsp_exp, t_rsp_frac}, 41'd0);
        chk("to_keep_sincos_tag", {t_rsp_sincos, t_rsp_tag}, {1'b1, 4'd9});
        chk("to_sticky_err", t_err, 1'b1);
        step(1);
        chk("to_rsp_drop", t_rsp_valid, 1'b0);
        core_pulse(1'b1, 1'b1, 8'h77, 32'h0000_AAAA, 1'b0);
        chk("to_late_ignored", t_rsp_valid, 1'b0);
        chk("to_late_no_corrupt", t_rsp_frac, 32'd0);
        step(5);
        chk("to_err_stays", t_err, 1'b1);

        // result on the timeout cycle wins over the error
        push_req(1'b1, 1'b0, 8'h66, 32'h0000_5678, 1'b0, 4'd3);
        step(2);
        step(7);
        chk("race_not_yet", t_rsp_valid, 1'b0);
        core_pulse(1'b1, 1'b0, 8'h12, 32'h0BAD_F00D, 1'b0);
        chk("race_rsp_valid", t_rsp_valid, 1'b1);
        chk("race_rsp_err", t_rsp_err, 1'b0);
        chk("race_rsp_frac", t_rsp_frac, 32'h0BAD_F00D);
        chk("race_rsp_tag", t_rsp_tag, 4'd3);
        step(1);

        // asynchronous reset while waiting with three requests queued
        push_req(1'b0, 1'b0, 8'h01, 32'h0000_0001, 1'b0, 4'd1);
        step(2);
        push_req(1'b0, 1'b0, 8'h02, 32'h0000_0002, 1'b0, 4'd2);
        push_req(1'b0, 1'b0, 8'h03, 32'h0000_0003, 1'b0, 4'd3);
        push_req(1'b0, 1'b0, 8'h04, 32'h0000_0004, 1'b0, 4'd4);
        chk("rstw_count3", count, 3'd3);
        rstn = 1'b0;
        #2;
        chk("rstw_count0", count, 3'd0);
        chk("rstw_core_out", {oc_valid, oc_sign, oc_exp, oc_frac, oc_sincos}, 42'd0);
        chk("rstw_rsp_out", {rsp_valid, rsp_err, rsp_tag, rsp_frac}, 38'd0);
        chk("rstw_t_err", {t_err, t_rsp_err}, 2'd0);
        #2;
        rstn = 1'b1;
        step(1);
        push_req(1'b0, 1'b1, 8'h7F, 32'h0F0F_0F0F, 1'b1, 4'hC);
        chk("post_rst_count", count, 3'd1);
        step(1);
        chk("post_rst_issue", oc_valid, 1'b1);
        chk("post_rst_frac", oc_frac, 32'h0F0F_0F0F);
        step(1);
        core_pulse(1'b0, 1'b0, 8'h7D, 32'h4444_4444, 1'b1);
        chk("post_rst_rsp_tag", rsp_tag, 4'hC);
        chk("post_rst_rsp_frac", rsp_frac, 32'h4444_4444);
        step(4);
        chk("post_rst_queue_empty", {oc_valid, count}, 4'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/sincos_dispatch.md
Name: sincos_dispatch

Overview:
- Request front-end for the single-issue sin/cos core (`top_single`).
- Buffers host operations in a FIFO and issues them to the core one at a time, honouring the core's allow/busy signal.
- Captures the core's one-cycle result pulse into a holding register and returns it with the host's tag over a valid/ready handshake.
- Includes a watchdog that recovers if a result never arrives.

Parameters:
- EXP_WIDTH, 8, exponent width of operand and result.
- FRAC_WIDTH, 32, fraction width of operand and result.
- TAG_WIDTH, 4, width of the host transaction tag.
- DEPTH, 4, request FIFO depth; must be a power of 2, at least 2.
- TIMEOUT, 255, maximum cycles in WAIT before abort; must be at least 1 and fit in 16 bits.

Ports:
- i_clk  in  1  clock
- i_rstn  in  1  asynchronous active-low reset
- i_req_valid  in  1  host request valid
- o_req_ready  out  1  FIFO can accept
- i_req_sign  in  1  operand sign
- i_req_exp  in  EXP_WIDTH  operand exponent
- i_req_frac  in  FRAC_WIDTH  operand fraction
- i_req_sincos  in  1  function select, passed through to the core
- i_req_tag  in  TAG_WIDTH  host tag
- o_core_valid  out  1  issue strobe to the core
- o_core_sign  out  1  operand sign to the core
- o_core_exp  out  EXP_WIDTH  operand exponent to the core
- o_core_frac  out  FRAC_WIDTH  operand fraction to the core
- o_core_sincos  out  1  function select to the core
- i_core_allow  in  1  core idle / can accept
- i_core_valid  in  1  core result pulse
- i_core_sign  in  1  result sign
- i_core_exp  in  EXP_WIDTH  result exponent
- i_core_frac  in  FRAC_WIDTH  result fraction
- i_core_sincos  in  1  result function select
- o_rsp_valid  out  1  response valid
- i_rsp_ready  in  1  consumer ready
- o_rsp_sign  out  1  response sign
- o_rsp_exp  out  EXP_WIDTH  response exponent
- o_rsp_frac  out  FRAC_WIDTH  response fraction
- o_rsp_sincos  out  1  response function select
- o_rsp_tag  out  TAG_WIDTH  tag of the issued request
- o_rsp_err  out  1  response produced by timeout; payload is zero
- o_count  out  clog2(DEPTH)+1  FIFO occupancy
- o_err  out  1  sticky timeout flag, cleared only by reset

Behaviour:
- Reset: every output, FIFO pointers, state and counters go to 0; state = IDLE.
- o_req_ready = (o_count < DEPTH). There is no bypass when the FIFO is full.
- A push occurs when i_req_valid & o_req_ready.
  - Push and pop in the same cycle leave o_count unchanged.
  - Pointers wrap modulo DEPTH.
- FIFO storage is registers only. Push and pop are registered; head data is read combinationally.
- State machine, IDLE / ISSUE / WAIT / HOLD:
  - can_issue = FIFO not empty & i_core_allow & (state==IDLE | (state==HOLD & i_rsp_ready)).
  - IDLE: if can_issue, pop the head into the o_core_* registers, latch the tag into tag_q, set o_core_valid=1, go to ISSUE.
  - ISSUE: o_core_valid and o_core_* hold until a cycle with o_core_valid & i_core_allow.
    - At that edge, drop o_core_valid, clear the watchdog, go to WAIT.
    - o_core_* payload is stable throughout ISSUE.
  - WAIT: increment the watchdog each cycle.
    - On i_core_valid: register the i_core_* payload and tag_q into o_rsp_*, set o_rsp_valid=1, o_rsp_err=0, go to HOLD.
    - If the watchdog reaches TIMEOUT with no i_core_valid: set o_rsp_valid=1, o_rsp_err=1, zero the sign/exp/frac fields, keep sincos and tag, set o_err=1, go to HOLD.
    - i_core_valid in the same cycle as timeout: the result wins and there is no error.
  - HOLD: o_rsp_* is stable while o_rsp_valid & !i_rsp_ready.
    - On i_rsp_ready: if can_issue, perform the IDLE issue actions in the same cycle (o_rsp_valid drops, o_core_valid rises) and go to ISSUE; else clear o_rsp_valid and go to IDLE.
- i_core_valid outside WAIT is ignored. It must not corrupt o_rsp_*.
- At most one operation is in flight. Results return in request order.
- Minimum latency:
  - Push at edge E0; o_core_valid visible after E1; core accepts at E2.
  - o_rsp_valid is high the cycle after the edge that samples i_core_valid.
- Asynchronous reset mid-operation: everything is dropped immediately, including FIFO contents and any in-flight tag.

Test Plan:
- Single op: push {sign 0, exp 0x7E, frac 0x80000000, sincos 1, tag 5} into an empty FIFO with allow=1.
  - o_core_valid pulses exactly one cycle, 2 cycles after the push.
  - A model returns i_core_valid 10 cycles later: o_rsp_valid the next cycle with tag 5, err 0, payload equal to the model's.
- Backpressure fill: hold i_core_allow=0 and push 5 requests with DEPTH=4.
  - o_req_ready=0 after the 4th push; o_count=4; the 5th is accepted only after the first pop.
  - Responses come out in order with tags 0,1,2,3,4.
- Allow stall: allow=0 for 3 cycles while o_core_valid=1.
  - Payload stays stable; acceptance happens on the first cycle allow=1; no duplicate issue.
- Response stall: i_rsp_ready=0 for 6 cycles in HOLD.
  - o_rsp_* is stable; no issue occurs; on ready=1 with the FIFO non-empty, o_core_valid rises in the same cycle o_rsp_valid drops.
- Timeout: TIMEOUT=8 and the core never responds.
  - 8 cycles after entering WAIT: o_rsp_valid=1, o_rsp_err=1, frac=0, o_err stays 1 until reset.
  - A late i_core_valid after that is ignored.
- Reset while in WAIT with 3 queued requests: all outputs are 0 and o_count=0 at once; a fresh request after reset is processed normally.
